seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_div_cond_negate.sv | 14 +
 rtl/seq_divider.sv | 127 ++++++++++++
 tb/tb_seq_divider.sv | 134 +++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants and types for the sequential RV32M divide unit.
// Optional early-out build is selected with SEQ_DIVIDER_EARLY_OUT_EN.
package seq_divider_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  localparam logic [XLEN_DEF-1:0] ALL_ONES   = {XLEN_DEF{1'b1}};
  localparam logic [XLEN_DEF-1:0] SIGNED_MIN = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/seq_divider_div_cond_negate.sv
// Combinational conditional two's-complement negate.
module div_cond_negate
  import seq_divider_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic            en,
  output logic [XLEN-1:0] y
);

  assign y = en ? ((~a) + XLEN'(1)) : a;

endmodule

// File: rtl/seq_divider.sv
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define SEQ_DIVIDER_EARLY_OUT_EN to finish trivial cases at the accepting edge.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  state_t          state;
  logic [1:0]      op_q;
  logic            neg_quo, neg_rem, dz;
  logic [XLEN-1:0] quo, rem, dvs;
  logic [CW-1:0]   count;

  logic            in_signed, dvd_neg, dvs_neg;
  logic [XLEN-1:0] dvd_abs, dvs_abs, quo_fix, rem_fix, rem_sh;
  logic [XLEN:0]   diff;

  assign in_signed = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign dvd_neg   = in_signed & dividend[XLEN-1];
  assign dvs_neg   = in_signed & divisor[XLEN-1];

  div_cond_negate #(.XLEN(XLEN)) u_abs_dvd (.a(dividend), .en(dvd_neg), .y(dvd_abs));
  div_cond_negate #(.XLEN(XLEN)) u_abs_dvs (.a(divisor),  .en(dvs_neg), .y(dvs_abs));
  div_cond_negate #(.XLEN(XLEN)) u_neg_quo (.a(quo),      .en(neg_quo), .y(quo_fix));
  div_cond_negate #(.XLEN(XLEN)) u_neg_rem (.a(rem),      .en(neg_rem), .y(rem_fix));

  // Trial subtract one bit wider than the operands; bit XLEN is the borrow.
  assign rem_sh = {rem[XLEN-2:0], quo[XLEN-1]};
  assign diff   = {1'b0, rem_sh} - {1'b0, dvs};

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  logic            early;
  logic [XLEN-1:0] early_res;

  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (divisor == '0) begin
      early     = 1'b1;
      early_res = op[1] ? dividend : ONES;
    end else if (in_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == ONES)) begin
      early     = 1'b1;
      early_res = op[1] ? '0 : dividend;
    end else if (dvs_abs > dvd_abs) begin
      early     = 1'b1;
      early_res = op[1] ? dividend : '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      op_q    <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            neg_quo <= dvd_neg ^ dvs_neg;
            neg_rem <= dvd_neg;
            dz      <= (divisor == '0);
            quo     <= dvd_abs;
            dvs     <= dvs_abs;
            rem     <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= CALC;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
            if (early) begin
              result <= early_res;
              done   <= 1'b1;
              state  <= DONE;
            end
`endif
          end
        end
        CALC: begin
          rem   <= diff[XLEN] ? rem_sh : diff[XLEN-1:0];
          quo   <= {quo[XLEN-2:0], ~diff[XLEN]};
          count <= count + CW'(1);
          if (count == LAST) state <= FIXUP;
        end
        FIXUP: begin
          // Signed divide by zero would otherwise pick up the dividend's sign.
          if (op_q[1])               result <= rem_fix;
          else if (dz && !op_q[0])   result <= ONES;
          else                       result <= quo_fix;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (both early-out builds).
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  localparam int NL = 33;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam int EL = 0;
`else
  localparam int EL = 33;
`endif

  seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // done_edge counts edges after the accepting edge 0 at which done is first seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_edge, input string tag);
    int  done_edge;
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    assert (busy === 1'b1) else begin errors++; $error("FAIL %s busy: observed %0b expected 1", tag, busy); end
    done_edge = 0;
    while (done !== 1'b1 && done_edge < 80) begin
      @(posedge clk); #1;
      done_edge++;
    end
    checks++;
    assert (done_edge === exp_edge) else begin errors++; $error("FAIL %s latency: observed %0d expected %0d", tag, done_edge, exp_edge); end
    checks++;
    assert (result === exp) else begin errors++; $error("FAIL %s result: observed %h expected %h", tag, result, exp); end
    @(posedge clk); #1;
    checks++;
    assert ({busy, done} === 2'b00) else begin errors++; $error("FAIL %s end: observed busy/done %b expected 00", tag, {busy, done}); end
  endtask

  initial begin
    int          ndone;
    logic [31:0] res;

    #12;
    checks++;
    assert ({busy, done, result} === 34'd0) else begin errors++; $error("FAIL reset: observed %b/%b/%h expected 0/0/0", busy, done, result); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op(2'b01, 32'd100, 32'd7, 32'd14, NL, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, NL, "remu_100_7");
    run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, NL, "div_m100_7");
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, NL, "rem_m100_7");
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, NL, "rem_100_m7");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hC000_0000, 32'd1, NL, "divu_big");
    run_op(2'b11, 32'hFFFF_FFFF, 32'hC000_0000, 32'h3FFF_FFFF, NL, "remu_big");

    run_op(2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, EL, "divu_zero");
    run_op(2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, EL, "div_zero");
    run_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, EL, "remu_zero");
    run_op(2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, EL, "rem_zero");
    run_op(2'b00, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, EL, "div_zero_neg");

    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EL, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EL, "rem_ovf");

    run_op(2'b01, 32'd5, 32'd9, 32'd0, EL, "divu_small");
    run_op(2'b10, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFFB, EL, "rem_small_neg");

    // Ignored starts and operand changes while busy.
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; res = '0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 5 || cyc == 20) begin
        start = 1'b1; dividend = 32'd77; divisor = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (cyc == 10) dividend = 32'd5555;
      @(posedge clk); #1;
      if (done === 1'b1) begin ndone++; res = result; end
    end
    start = 1'b0;
    checks++;
    assert (ndone === 1) else begin errors++; $error("FAIL ignored_start dones: observed %0d expected 1", ndone); end
    checks++;
    assert (res === 32'd100) else begin errors++; $error("FAIL ignored_start result: observed %h expected %h", res, 32'd100); end
    checks++;
    assert (result === 32'd100) else begin errors++; $error("FAIL held_result: observed %h expected %h", result, 32'd100); end

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd4000; divisor = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert ({busy, done, result} === 34'd0) else begin errors++; $error("FAIL mid_reset: observed %b/%b/%h expected 0/0/0", busy, done, result); end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    assert (ndone === 0) else begin errors++; $error("FAIL post_reset_activity: observed %0d expected 0", ndone); end
    run_op(2'b01, 32'd9, 32'd3, 32'd3, NL, "divu_9_3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
